pr_queue_drain_master: RTL and testbench
========================================

// Module: pr_queue_drain_master
// PURPOSE
// - AXI-lite master that drains the CPU's PR request queue through the core's 2-bit-addressed s_axi slave port.
// - On pr_request_pending: reads queue head (pop), hands the request to the reconfiguration controller over valid/ready,
//   waits for pr_done, then writes a completion word back to the queue. Sits directly downstream of the CPU wrapper's s_axi_*/pr_request_pending.
// PARAMETERS
// - HEAD_ADDR     2'd0     register index read to pop queue head; rdata==0 means queue empty
// - DONE_ADDR     2'd2     register index written with completion word
// - TIMEOUT_CYCLES 1<<20   WAIT_DONE watchdog limit (used only with PR_TIMEOUT_EN)
// PORTS
// - clk                 in   1   core clock
// - rst                 in   1   asynchronous, active-high reset
// - pr_request_pending  in   1   queue non-empty flag from CPU wrapper
// - m_arvalid/m_arready out/in 1  read address handshake; m_araddr out 2
// - m_rvalid/m_rready   in/out 1  read data handshake; m_rdata in 32 (request id)
// - m_awvalid/m_awready out/in 1  write address handshake; m_awaddr out 2
// - m_wvalid/m_wready   out/in 1  write data handshake; m_wdata out 32
// - m_bvalid/m_bready   in/out 1  write response handshake
// - pr_req_valid        out  1   request to reconfiguration controller
// - pr_req_id           out  32  request id (held stable while pr_req_valid)
// - pr_req_ready        in   1   controller accepts request
// - pr_done             in   1   single-cycle completion pulse from controller
// - pr_error            in   1   error flag, qualified by pr_done
// - busy                out  1   FSM not in IDLE
// - err_count           out  8   saturating count of failed/timed-out requests
// BEHAVIOUR
// - Reset (async): state=IDLE; all valid/ready outputs 0; m_araddr=HEAD_ADDR, m_awaddr=DONE_ADDR, m_wdata=0, pr_req_id=0, err_count=0.
// - IDLE: pending=1 -> AR (arvalid=1 next cycle). Minimum one IDLE cycle between requests.
// - AR: hold arvalid until arready; then RD with rready=1. pending falling during AR is ignored (AXI valid never withdrawn).
// - RD: on rvalid&rready capture rdata into pr_req_id; rdata==0 -> IDLE (empty, no writeback); else DISPATCH.
// - DISPATCH: pr_req_valid=1, id stable; on pr_req_ready -> WAIT_DONE. pr_done here is ignored (controller must pulse done >=1 cycle after accept).
// - WAIT_DONE: on pr_done latch {err=pr_error, to=0} -> WR.
// - WR: awvalid and wvalid asserted together; each deasserts independently on its own ready; -> RESP when both accepted (any order, same cycle allowed).
// - m_wdata = {err, to, pr_req_id[29:0]}.
// - RESP: bready=1; on bvalid -> IDLE; err_count += (err|to), saturates at 8'hFF.
// - Registered outputs only; request pop-to-dispatch latency = AR handshake + R handshake + 1 cycle.
// - busy = (state != IDLE), combinational from state.
// CONFIGURATION
// - PR_TIMEOUT_EN defined: 32-bit counter cleared on WAIT_DONE entry, increments each WAIT_DONE cycle; reaching TIMEOUT_CYCLES -> latch {err=0,to=1} -> WR.
//   pr_done on the same cycle as timeout wins (to=0). A later pr_done from that request is ignored.
// - PR_TIMEOUT_EN undefined: no counter; WAIT_DONE waits indefinitely; m_wdata[30] always 0.
// TESTING
// - Single request: pending=1, rdata=32'h0000_0005, ready immediate, pr_done pulse err=0 -> pr_req_id=5, wdata=32'h0000_0005 to addr 2, err_count=0.
// - Empty pop: pending=1, rdata=0 -> no pr_req_valid, no AW/W, return to IDLE.
// - Backpressure: arready/rready/pr_req_ready/awready/wready low 3-7 random cycles, wready before awready -> valids held stable, exactly one AW and one W.
// - Error: pr_done with pr_error=1 for id 9 -> wdata=32'h8000_0009, err_count increments; 256 errors -> err_count stays 8'hFF.
// - Timeout (PR_TIMEOUT_EN, TIMEOUT_CYCLES=16): no pr_done -> WR after 16 WAIT_DONE cycles, wdata=32'h4000_00id; done on cycle 16 -> wdata bit30=0.
// - Async rst asserted in WR mid-handshake -> all valids 0 same cycle, state IDLE, no further AXI activity until pending.

Source files
------------

// File: rtl/pr_queue_drain_master.sv
// AXI-lite master that pops PR requests from the CPU queue, dispatches them, and writes back a completion word.
// Optional WAIT_DONE watchdog is enabled by defining PR_TIMEOUT_EN.
module pr_queue_drain_master #(
  parameter logic [1:0]  HEAD_ADDR      = 2'd0,
  parameter logic [1:0]  DONE_ADDR      = 2'd2,
  parameter int unsigned TIMEOUT_CYCLES = 1 << 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pr_request_pending,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [1:0]  m_araddr,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [31:0] m_rdata,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [1:0]  m_awaddr,
  output logic        m_wvalid,
  input  logic        m_wready,
  output logic [31:0] m_wdata,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic        pr_req_valid,
  output logic [31:0] pr_req_id,
  input  logic        pr_req_ready,
  input  logic        pr_done,
  input  logic        pr_error,
  output logic        busy,
  output logic [7:0]  err_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_RD, S_DISPATCH, S_WAIT_DONE, S_WR, S_RESP
  } state_t;

  state_t      state_q;
  logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q, req_valid_q;
  logic [31:0] req_id_q, wdata_q;
  logic [7:0]  err_cnt_q;
  logic        awvalid_d, wvalid_d;

  if (TIMEOUT_CYCLES == 0) begin : g_tmo_chk
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef PR_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tmr_q;
`endif

  // AW and W channels retire independently; each stays up only until its own ready.
  assign awvalid_d = awvalid_q & ~m_awready;
  assign wvalid_d  = wvalid_q & ~m_wready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      req_valid_q <= 1'b0;
      req_id_q    <= 32'd0;
      wdata_q     <= 32'd0;
      err_cnt_q   <= 8'd0;
`ifdef PR_TIMEOUT_EN
      tmr_q       <= 32'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pr_request_pending) begin
            arvalid_q <= 1'b1;
            state_q   <= S_AR;
          end
        end
        S_AR: begin
          if (m_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RD;
          end
        end
        S_RD: begin
          if (m_rvalid) begin
            rready_q <= 1'b0;
            req_id_q <= m_rdata;
            if (m_rdata == 32'd0) begin
              state_q <= S_IDLE;
            end else begin
              req_valid_q <= 1'b1;
              state_q     <= S_DISPATCH;
            end
          end
        end
        S_DISPATCH: begin
          if (pr_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= S_WAIT_DONE;
`ifdef PR_TIMEOUT_EN
            tmr_q       <= 32'd0;
`endif
          end
        end
        S_WAIT_DONE: begin
          if (pr_done) begin
            wdata_q   <= {pr_error, 1'b0, req_id_q[29:0]};
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= S_WR;
          end
`ifdef PR_TIMEOUT_EN
          else if (tmr_q == TMO_LAST) begin
            wdata_q   <= {1'b0, 1'b1, req_id_q[29:0]};
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= S_WR;
          end else begin
            tmr_q <= tmr_q + 32'd1;
          end
`endif
        end
        S_WR: begin
          awvalid_q <= awvalid_d;
          wvalid_q  <= wvalid_d;
          if (!awvalid_d && !wvalid_d) begin
            bready_q <= 1'b1;
            state_q  <= S_RESP;
          end
        end
        S_RESP: begin
          if (m_bvalid) begin
            bready_q <= 1'b0;
            state_q  <= S_IDLE;
            // Error and timeout flags live in the completion word just written.
            if ((wdata_q[31] | wdata_q[30]) && (err_cnt_q != 8'hFF)) begin
              err_cnt_q <= err_cnt_q + 8'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m_arvalid    = arvalid_q;
  assign m_araddr     = HEAD_ADDR;
  assign m_rready     = rready_q;
  assign m_awvalid    = awvalid_q;
  assign m_awaddr     = DONE_ADDR;
  assign m_wvalid     = wvalid_q;
  assign m_wdata      = wdata_q;
  assign m_bready     = bready_q;
  assign pr_req_valid = req_valid_q;
  assign pr_req_id    = req_id_q;
  assign err_count    = err_cnt_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_pr_queue_drain_master.sv
// Directed bench for pr_queue_drain_master: scoreboarded request ids and completion words.
module tb_pr_queue_drain_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        pr_request_pending;
  logic        m_arvalid, m_arready;
  logic [1:0]  m_araddr;
  logic        m_rvalid, m_rready;
  logic [31:0] m_rdata;
  logic        m_awvalid, m_awready;
  logic [1:0]  m_awaddr;
  logic        m_wvalid, m_wready;
  logic [31:0] m_wdata;
  logic        m_bvalid, m_bready;
  logic        pr_req_valid;
  logic [31:0] pr_req_id;
  logic        pr_req_ready, pr_done, pr_error;
  logic        busy;
  logic [7:0]  err_count;

  int errors = 0;
  int checks = 0;
  int ar_cnt = 0;
  int aw_cnt = 0;
  int w_cnt  = 0;
  logic [31:0] exp_id_q[$];
  logic [31:0] exp_wd_q[$];
  logic [7:0]  exp_errs = 8'd0;

  always #5 clk = ~clk;

  pr_queue_drain_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .pr_request_pending(pr_request_pending),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .pr_req_valid(pr_req_valid), .pr_req_id(pr_req_id), .pr_req_ready(pr_req_ready),
    .pr_done(pr_done), .pr_error(pr_error), .busy(busy), .err_count(err_count)
  );

  always @(posedge clk) begin
    if (m_arvalid && m_arready) ar_cnt <= ar_cnt + 1;
    if (m_awvalid && m_awready) aw_cnt <= aw_cnt + 1;
    if (m_wvalid && m_wready)   w_cnt  <= w_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ar_phase(input int bp);
    int n = 0;
    while (!m_arvalid && n < 40) begin @(negedge clk); n++; end
    chk("ar_valid", {31'd0, m_arvalid}, 32'd1);
    chk("ar_addr", {30'd0, m_araddr}, 32'd0);
    pr_request_pending = 1'b0;
    repeat (bp) begin
      @(negedge clk);
      chk("ar_hold", {29'd0, m_arvalid, m_araddr}, 32'd4);
    end
    m_arready = 1'b1;
    @(negedge clk);
    m_arready = 1'b0;
  endtask

  task automatic r_phase(input logic [31:0] id, input logic [31:0] wexp, input int bp);
    int n = 0;
    while (!m_rready && n < 40) begin @(negedge clk); n++; end
    chk("r_ready", {31'd0, m_rready}, 32'd1);
    repeat (bp) begin
      @(negedge clk);
      chk("r_hold", {31'd0, m_rready}, 32'd1);
    end
    m_rvalid = 1'b1;
    m_rdata  = id;
    if (id != 32'd0) begin
      exp_id_q.push_back(id);
      exp_wd_q.push_back(wexp);
    end
    @(negedge clk);
    m_rvalid = 1'b0;
    m_rdata  = $urandom;
    chk("r_drop", {31'd0, m_rready}, 32'd0);
    chk("disp_latency", {31'd0, pr_req_valid}, {31'd0, id != 32'd0});
  endtask

  task automatic disp_phase(input int bp);
    logic [31:0] e;
    chk("req_valid", {31'd0, pr_req_valid}, 32'd1);
    e = exp_id_q.pop_front();
    chk("req_id", pr_req_id, e);
    for (int k = 0; k < bp; k++) begin
      pr_done = (k == 0);
      @(negedge clk);
      chk("req_hold_valid", {31'd0, pr_req_valid}, 32'd1);
      chk("req_hold_id", pr_req_id, e);
    end
    pr_done = 1'b0;
    pr_req_ready = 1'b1;
    @(negedge clk);
    pr_req_ready = 1'b0;
    chk("req_drop", {31'd0, pr_req_valid}, 32'd0);
  endtask

  task automatic done_phase(input logic err, input int wt);
    pr_error = 1'b1;
    repeat (wt) begin
      @(negedge clk);
      chk("wait_no_aw", {30'd0, m_awvalid, busy}, 32'd1);
    end
    pr_done  = 1'b1;
    pr_error = err;
    @(negedge clk);
    pr_done  = 1'b0;
    pr_error = 1'($urandom);
  endtask

  task automatic wr_phase(input int bp);
    int a0 = aw_cnt;
    int w0 = w_cnt;
    logic [31:0] e;
    int n = 0;
    while (!m_awvalid && n < 40) begin @(negedge clk); n++; end
    e = exp_wd_q.pop_front();
    chk("wr_valids", {30'd0, m_awvalid, m_wvalid}, 32'd3);
    chk("aw_addr", {30'd0, m_awaddr}, 32'd2);
    chk("wdata", m_wdata, e);
    if (bp == 0) begin
      m_awready = 1'b1;
      m_wready  = 1'b1;
      @(negedge clk);
      m_awready = 1'b0;
      m_wready  = 1'b0;
    end else begin
      repeat (bp) begin
        @(negedge clk);
        chk("wr_hold", {30'd0, m_awvalid, m_wvalid}, 32'd3);
        chk("wdata_hold", m_wdata, e);
      end
      m_wready = 1'b1;
      @(negedge clk);
      m_wready = 1'b0;
      chk("w_first", {30'd0, m_awvalid, m_wvalid}, 32'd2);
      repeat (2) @(negedge clk);
      m_awready = 1'b1;
      @(negedge clk);
      m_awready = 1'b0;
    end
    chk("aw_count", aw_cnt - a0, 32'd1);
    chk("w_count", w_cnt - w0, 32'd1);
    chk("wr_done", {30'd0, m_awvalid, m_wvalid}, 32'd0);
  endtask

  task automatic b_phase(input int bp, input logic err);
    chk("b_ready", {31'd0, m_bready}, 32'd1);
    repeat (bp) begin
      @(negedge clk);
      chk("b_hold", {31'd0, m_bready}, 32'd1);
    end
    m_bvalid = 1'b1;
    @(negedge clk);
    m_bvalid = 1'b0;
    chk("b_idle", {30'd0, m_bready, busy}, 32'd0);
    if (err && exp_errs != 8'hFF) exp_errs = exp_errs + 8'd1;
    chk("err_count", {24'd0, err_count}, {24'd0, exp_errs});
  endtask

  task automatic run_req(input logic [31:0] id, input logic err, input int bp);
    pr_request_pending = 1'b1;
    ar_phase(bp);
    r_phase(id, {err, 1'b0, id[29:0]}, bp);
    if (id == 32'd0) begin
      repeat (4) begin
        @(negedge clk);
        chk("empty_quiet", {30'd0, pr_req_valid, m_awvalid}, 32'd0);
      end
      chk("empty_idle", {31'd0, busy}, 32'd0);
      chk("empty_id", pr_req_id, 32'd0);
    end else begin
      disp_phase(bp);
      done_phase(err, bp + 1);
      wr_phase(bp);
      b_phase(bp, err);
    end
  endtask

  initial begin
    int a0;
    rst = 1'b1;
    pr_request_pending = 1'b0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'd0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
    pr_req_ready = 1'b0; pr_done = 1'b0; pr_error = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valids", {25'd0, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, pr_req_valid, busy}, 32'd0);
    chk("rst_addrs", {28'd0, m_araddr, m_awaddr}, 32'd2);
    chk("rst_wdata", m_wdata, 32'd0);
    chk("rst_id", pr_req_id, 32'd0);
    chk("rst_errs", {24'd0, err_count}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_req(32'h0000_0005, 1'b0, 0);
    run_req(32'h0000_0000, 1'b0, 0);
    run_req(32'h0000_00A5, 1'b0, 3);
    run_req(32'h0000_1234, 1'b0, int'($urandom_range(3, 7)));
    run_req(32'h0000_0009, 1'b1, 0);
    run_req(32'hFFFF_FFFF, 1'b0, 1);
    for (int i = 0; i < 256; i++) run_req(32'h100 + i, 1'b1, 0);
    chk("err_sat", {24'd0, err_count}, 32'hFF);

    // Reset lands while the completion write is stalled.
    pr_request_pending = 1'b1;
    ar_phase(1);
    r_phase(32'h0000_0007, 32'h0000_0007, 0);
    disp_phase(0);
    done_phase(1'b0, 1);
    chk("pre_rst_wr", {30'd0, m_awvalid, m_wvalid}, 32'd3);
    chk("pre_rst_wdata", m_wdata, exp_wd_q.pop_front());
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_valids", {25'd0, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, pr_req_valid, busy}, 32'd0);
    #1 rst = 1'b0;
    exp_errs = 8'd0;
    chk("rst_mid_errs", {24'd0, err_count}, 32'd0);
    a0 = ar_cnt;
    repeat (8) begin
      @(negedge clk);
      chk("post_rst_quiet", {30'd0, m_arvalid, m_awvalid}, 32'd0);
    end
    chk("post_rst_ar", ar_cnt - a0, 32'd0);
    run_req(32'h0000_0006, 1'b0, 2);

`ifdef PR_TIMEOUT_EN
    pr_request_pending = 1'b1;
    ar_phase(0);
    r_phase(32'h0000_0033, 32'h4000_0033, 0);
    disp_phase(0);
    repeat (15) begin
      @(negedge clk);
      chk("tmo_wait", {31'd0, m_awvalid}, 32'd0);
    end
    @(negedge clk);
    chk("tmo_fire", {31'd0, m_awvalid}, 32'd1);
    wr_phase(0);
    b_phase(0, 1'b1);

    pr_request_pending = 1'b1;
    ar_phase(0);
    r_phase(32'h0000_0044, 32'h0000_0044, 0);
    disp_phase(0);
    repeat (15) @(negedge clk);
    pr_done = 1'b1;
    pr_error = 1'b0;
    @(negedge clk);
    pr_done = 1'b0;
    wr_phase(0);
    b_phase(0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
